// File: rtl/kbd_pkg.sv
// ---------------------------------------------------------------------------
// kbd_pkg
// Definitions shared by the PS/2 set-2 key decoder:
//   - scancode byte constants (prefixes, mapped keys, keyboard status codes)
//   - kbd_state_t : decoder sequence state
//   - kbd_held_t  : held-key flag bundle
// ---------------------------------------------------------------------------
package kbd_pkg;

  // Sequence prefixes
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;

  // Mapped keys (plain codes)
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_A      = 8'h1C;
  localparam logic [7:0] SC_D      = 8'h23;
  localparam logic [7:0] SC_ESC    = 8'h76;

  // Mapped keys (E0-prefixed codes)
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;

  // Keyboard status / reply codes; they decode as "no key" and are ignored
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ECHO   = 8'hEE;

  // Pause is E1 followed by seven more bytes that carry no key state
  localparam logic [2:0] PAUSE_SKIP_BYTES = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BRK     = 3'd1,
    ST_EXT     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_SKIP    = 3'd4
  } kbd_state_t;

  typedef struct packed {
    logic space;  // Space
    logic la;     // Left arrow
    logic ra;     // Right arrow
    logic a;      // A
    logic d;      // D
  } kbd_held_t;

endpackage

// File: rtl/kbd_seq_timer.sv
// ---------------------------------------------------------------------------
// kbd_seq_timer
// Saturating inter-byte gap counter. Counts while enabled, is zeroed on
// clear or while disabled, and flags expiry once it reaches
// TIMEOUT_CYCLES-1 (it then holds there until cleared or disabled).
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   clear_i    restart the gap measurement (a byte arrived)
//   enable_i   a multi-byte sequence is in progress
//   expired_o  gap limit reached (combinational from the count register)
// ---------------------------------------------------------------------------
module kbd_seq_timer #(
  parameter int TIMEOUT_CYCLES = 200_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: next-state defaults first so every path assigns cnt_d; a missing
    // branch in always_comb would otherwise infer a latch.
    cnt_d = cnt_q;
    if (clear_i || !enable_i) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/kbd_key_decoder.sv
// ---------------------------------------------------------------------------
// kbd_key_decoder
// Turns the PS/2 set-2 scancode byte stream into held-key levels for the
// character controller (Space, Left = arrow or A, Right = arrow or D) and a
// one-cycle Esc pulse. Handles F0 break and E0 extended prefixes, skips the
// 8-byte Pause sequence, abandons a sequence whose inter-byte gap exceeds
// TIMEOUT_CYCLES, and drops every held key on a receiver error.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   rx_data[7:0]   received byte, qualified by rx_valid
//   rx_valid       one-cycle byte strobe
//   rx_error       one-cycle parity/framing error strobe (beats rx_valid)
//   key_space      Space held
//   key_left       Left arrow or A held (see LR_CANCEL)
//   key_right      Right arrow or D held (see LR_CANCEL)
//   key_esc_pulse  one-cycle pulse per Esc make
// All outputs are registered: a change appears one cycle after the strobe
// carrying the last byte of its sequence.
// ---------------------------------------------------------------------------
module kbd_key_decoder
  import kbd_pkg::*;
#(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int TIMEOUT_CYCLES = 200_000,
  parameter bit LR_CANCEL      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_error,
  output logic       key_space,
  output logic       key_left,
  output logic       key_right,
  output logic       key_esc_pulse
);

  // CLK_FREQ only documents the time base of TIMEOUT_CYCLES; a nonsensical
  // setting falls back to the shortest usable timeout.
  localparam int TIMEOUT_EFF =
    (CLK_FREQ > 0 && TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES : 2;

  kbd_state_t state_q, state_d;
  logic [2:0] skip_q, skip_d;
  kbd_held_t  held_q, held_d;
  logic       space_q, left_q, right_q, esc_q;
  logic       space_d, left_d, right_d, esc_d;
  logic       timeout;
  logic       l_any, r_any, lr_cancel;

  kbd_seq_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_EFF)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (rx_valid | rx_error),
    .enable_i  (state_q != ST_IDLE),
    .expired_o (timeout)
  );

  // Sequence decode. Priority: receiver error, then a byte, then timeout,
  // so a byte arriving on the expiry cycle still completes its sequence.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    held_d  = held_q;
    esc_d   = 1'b0;

    if (rx_error) begin
      // Lost byte may have been a break: drop everything rather than risk
      // a stuck key.
      state_d = ST_IDLE;
      skip_d  = '0;
      held_d  = '0;
    end else if (rx_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          unique case (rx_data)
            SC_BRK:   state_d = ST_BRK;
            SC_EXT:   state_d = ST_EXT;
            SC_PAUSE: begin
              state_d = ST_SKIP;
              skip_d  = PAUSE_SKIP_BYTES;
            end
            SC_SPACE: held_d.space = 1'b1;
            SC_A:     held_d.a     = 1'b1;
            SC_D:     held_d.d     = 1'b1;
            SC_ESC:   esc_d        = 1'b1;
            default:  ;  // ACK/BAT/resend/echo and unmapped keys
          endcase
        end

        ST_BRK: begin
          state_d = ST_IDLE;
          unique case (rx_data)
            SC_SPACE: held_d.space = 1'b0;
            SC_A:     held_d.a     = 1'b0;
            SC_D:     held_d.d     = 1'b0;
            default:  ;
          endcase
        end

        ST_EXT: begin
          state_d = ST_IDLE;
          unique case (rx_data)
            SC_BRK:   state_d   = ST_EXT_BRK;
            SC_LEFT:  held_d.la = 1'b1;
            SC_RIGHT: held_d.ra = 1'b1;
            default:  ;  // print-screen fillers 12/7C and unmapped keys
          endcase
        end

        ST_EXT_BRK: begin
          state_d = ST_IDLE;
          unique case (rx_data)
            SC_LEFT:  held_d.la = 1'b0;
            SC_RIGHT: held_d.ra = 1'b0;
            default:  ;
          endcase
        end

        ST_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
          skip_d  = '0;
        end
      endcase
    end else if (timeout) begin
      state_d = ST_IDLE;
      skip_d  = '0;
    end
  end

  // Output equations evaluated on the next flag values so the registered
  // outputs track the flags with no extra cycle.
  always_comb begin
    l_any     = held_d.la | held_d.a;
    r_any     = held_d.ra | held_d.d;
    lr_cancel = LR_CANCEL && l_any && r_any;
    space_d   = held_d.space;
    left_d    = l_any && !lr_cancel;
    right_d   = r_any && !lr_cancel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      skip_q  <= '0;
      held_q  <= '0;
      space_q <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      esc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      held_q  <= held_d;
      space_q <= space_d;
      left_q  <= left_d;
      right_q <= right_d;
      esc_q   <= esc_d;
    end
  end

  assign key_space     = space_q;
  assign key_left      = left_q;
  assign key_right     = right_q;
  assign key_esc_pulse = esc_q;

endmodule

// File: tb/tb_kbd_key_decoder.sv
// ---------------------------------------------------------------------------
// tb_kbd_key_decoder
// Directed scenarios with literal expectations, then randomized byte
// streams. A reference model tracks held keys as a small array and the
// pending sequence as a queue of prefix bytes plus a skip count; a compare
// process checks {space,left,right,esc} against it every cycle.
// ---------------------------------------------------------------------------
module tb_kbd_key_decoder;

  localparam int T = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_error = 1'b0;
  logic       key_space, key_left, key_right, key_esc_pulse;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  kbd_key_decoder #(
    .CLK_FREQ       (100_000_000),
    .TIMEOUT_CYCLES (T),
    .LR_CANCEL      (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_error      (rx_error),
    .key_space     (key_space),
    .key_left      (key_left),
    .key_right     (key_right),
    .key_esc_pulse (key_esc_pulse)
  );

  always #5 clk = ~clk;

  wire [3:0] dut_vec = {key_space, key_left, key_right, key_esc_pulse};

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got {space,left,right,esc}=%b expected %b", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // held index: 0 space, 1 left arrow, 2 right arrow, 3 A, 4 D
  bit          held [5];
  byte unsigned pre [$];
  int          skip_left = 0;
  longint      edge_n = 0;
  longint      last_edge = 0;
  bit          esc_exp = 1'b0;
  logic [3:0]  exp_out = 4'b0000;

  function automatic int key_of(input bit ext, input byte unsigned b);
    if (!ext) begin
      case (b)
        8'h29:   return 0;
        8'h1C:   return 3;
        8'h23:   return 4;
        default: return -1;
      endcase
    end else begin
      case (b)
        8'h6B:   return 1;
        8'h74:   return 2;
        default: return -1;
      endcase
    end
  endfunction

  task automatic model_clear_seq();
    pre.delete();
    skip_left = 0;
  endtask

  task automatic model_decode(input byte unsigned b);
    int k;
    bit ext, brk;
    if (skip_left > 0) begin
      skip_left--;
    end else if (pre.size() == 0) begin
      case (b)
        8'hF0, 8'hE0: pre.push_back(b);
        8'hE1:        skip_left = 7;
        8'h76:        esc_exp = 1'b1;
        default: begin
          k = key_of(1'b0, b);
          if (k >= 0) held[k] = 1'b1;
        end
      endcase
    end else if (pre.size() == 1 && pre[0] == 8'hE0 && b == 8'hF0) begin
      pre.push_back(b);
    end else begin
      ext = (pre[0] == 8'hE0);
      brk = (pre[pre.size()-1] == 8'hF0);
      k = key_of(ext, b);
      if (k >= 0) held[k] = !brk;
      pre.delete();
    end
  endtask

  task automatic model_step();
    bit l, r;
    edge_n++;
    esc_exp = 1'b0;
    if (rst) begin
      foreach (held[i]) held[i] = 1'b0;
      model_clear_seq();
    end else if (rx_error) begin
      foreach (held[i]) held[i] = 1'b0;
      model_clear_seq();
    end else if (rx_valid) begin
      // a sequence survives a gap of up to T cycles between its bytes
      if ((pre.size() > 0 || skip_left > 0) && (edge_n - last_edge > T))
        model_clear_seq();
      last_edge = edge_n;
      model_decode(rx_data);
    end
    l = held[1] | held[3];
    r = held[2] | held[4];
    exp_out = {held[0], l & ~(l & r), r & ~(l & r), esc_exp};
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (cmp_en) check("model_compare", dut_vec, exp_out);
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_err(input logic v, input logic [7:0] b);
    rx_data  = b;
    rx_valid = v;
    rx_error = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [3:0] exp);
    check(name, dut_vec, exp);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  byte unsigned pool [16] = '{8'hF0, 8'hE0, 8'hE1, 8'h29, 8'h1C, 8'h23, 8'h76, 8'h6B,
                              8'h74, 8'h12, 8'h7C, 8'hFA, 8'hAA, 8'h14, 8'h77, 8'hF0};
  byte unsigned pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  initial begin
    // reset
    rst = 1'b1;
    idle(3);
    expect_out("reset_state", 4'b0000);
    rst = 1'b0;
    cmp_en = 1'b1;

    // space make / break
    send(8'h29);             expect_out("space_make", 4'b1000);
    send(8'hF0);             expect_out("space_brk_prefix", 4'b1000);
    send(8'h29);             expect_out("space_break", 4'b0000);

    // arrows, A/D and L/R cancel
    send(8'hE0); send(8'h6B); expect_out("left_arrow_make", 4'b0100);
    send(8'h23);             expect_out("lr_cancel", 4'b0000);
    send(8'hF0); send(8'h23); expect_out("d_release", 4'b0100);
    send(8'hE0); send(8'hF0); send(8'h6B);
    expect_out("left_arrow_break", 4'b0000);

    // Esc pulses and ignored status codes
    send(8'h76);             expect_out("esc_pulse", 4'b0001);
    idle(1);                 expect_out("esc_one_cycle", 4'b0000);
    send(8'h76);             expect_out("esc_pulse_again", 4'b0001);
    send(8'hFA);             expect_out("ack_ignored", 4'b0000);
    send(8'hAA);             expect_out("bat_ignored", 4'b0000);

    // Pause sequence skipped in full
    foreach (pause_seq[i]) begin
      send(pause_seq[i]);
      expect_out("pause_quiet", 4'b0000);
    end
    send(8'h29);             expect_out("space_after_pause", 4'b1000);
    send(8'hF0); send(8'h29); expect_out("space_release2", 4'b0000);

    // abandoned break after timeout is not a release
    send(8'h1C);             expect_out("a_make", 4'b0100);
    send(8'hF0);
    idle(T + 5);             expect_out("timeout_hold", 4'b0100);
    send(8'h1C);             expect_out("timeout_not_release", 4'b0100);
    send(8'hF0); send(8'h1C); expect_out("a_release", 4'b0000);

    // receiver error with coincident byte
    send(8'h29); send(8'hE0); send(8'h74);
    expect_out("space_right_held", 4'b1010);
    send_err(1'b1, 8'hF0);   expect_out("error_clears_all", 4'b0000);
    send(8'h29);             expect_out("byte_after_error", 4'b1000);

    // gap exactly at the limit still completes; one more cycle abandons
    send(8'hF0); idle(T - 1); send(8'h29);
    expect_out("gap_at_limit_breaks", 4'b0000);
    send(8'h29);             expect_out("space_make3", 4'b1000);
    send(8'hF0); idle(T);    send(8'h29);
    expect_out("gap_over_limit_makes", 4'b1000);

    // reset in the middle of a break sequence
    send(8'hF0);
    rst = 1'b1; idle(1); rst = 1'b0;
    expect_out("reset_mid_seq", 4'b0000);
    send(8'h29);             expect_out("make_after_reset", 4'b1000);

    // randomized stream
    repeat (3000) begin
      int gap;
      logic [7:0] b;
      if ($urandom_range(0, 9) == 0) gap = $urandom_range(T - 3, T + 3);
      else                           gap = $urandom_range(0, 2);
      idle(gap);
      if ($urandom_range(0, 15) == 0) b = 8'($urandom);
      else                            b = pool[$urandom_range(0, 15)];
      if ($urandom_range(0, 49) == 0) send_err(1'($urandom), b);
      else                            send(b);
    end

    idle(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
